// File: rtl/tick_pkg.sv
// tick_pkg: state encoding and period helper shared by the tick period checker.
package tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // The source emits one strobe every counter_width+1 cycles.
    function automatic int expected_period(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/tick_period_checker_sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [width-1:0] o_count
);

    logic [width-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && r_count != '1)
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/tick_period_checker.sv
// tick_period_checker: measures spacing of incoming strobes, acquires lock and
// flags early or missing strobes.
module tick_period_checker
    import tick_pkg::*;
#(
    parameter int counter_width = 8,
    parameter int lock_count    = 3,
    parameter int err_width     = 8
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     tick_in,
    output logic                     locked,
    output logic                     period_err,
    output logic [err_width-1:0]     err_count,
    output logic [counter_width-1:0] last_period
);

    localparam logic [counter_width-1:0] P = counter_width'(expected_period(counter_width));
    localparam int MW = $clog2(lock_count + 1);

    state_t                   r_state, w_state_nxt;
    logic [counter_width-1:0] r_ic, w_ic_nxt;
    logic [counter_width-1:0] r_last, w_last_nxt;
    logic [MW-1:0]            r_match, w_match_nxt, w_match_inc;
    logic                     r_locked, r_err;
    logic                     w_active, w_good, w_err;

    always_comb begin
        w_match_inc = r_match + 1'b1;
        w_active    = r_state != ST_IDLE;
        w_good      = tick_in && r_ic == P;
        // Once active, a tick off the expected count or no tick at it is an error.
        w_err       = w_active && (tick_in ? r_ic != P : r_ic == P);
        w_ic_nxt    = tick_in ? counter_width'(1) : (r_ic == '1 ? r_ic : r_ic + 1'b1);
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_last_nxt  = r_last;
        if (!w_active) begin
            if (tick_in) begin
                w_state_nxt = ST_ACQUIRE;
                w_match_nxt = '0;
            end
        end else if (w_good) begin
            w_last_nxt = P;
            if (r_state == ST_ACQUIRE) begin
                w_match_nxt = w_match_inc;
                if (int'(w_match_inc) >= lock_count)
                    w_state_nxt = ST_LOCKED;
            end
        end else if (tick_in) begin
            w_last_nxt  = r_ic;
            w_state_nxt = ST_ACQUIRE;
            w_match_nxt = '0;
        end else if (w_err) begin
            w_state_nxt = ST_IDLE;
            w_match_nxt = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ic     <= '0;
            r_match  <= '0;
            r_last   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ic     <= w_ic_nxt;
            r_match  <= w_match_nxt;
            r_last   <= w_last_nxt;
            r_locked <= w_state_nxt == ST_LOCKED;
            r_err    <= w_err;
        end
    end

    sat_counter #(.width(err_width)) u_err_cnt (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_inc   (w_err),
        .i_clear (1'b0),
        .o_count (err_count)
    );

    assign locked      = r_locked;
    assign period_err  = r_err;
    assign last_period = r_last;

endmodule

// File: tb/tb_tick_period_checker.sv
// tb_tick_period_checker: scoreboard bench driving two checkers (lock_count 3 and 1)
// from a shared strobe stream.
module tb_tick_period_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       locked_a, err_a, locked_b, err_b;
    logic [7:0] cnt_a, cnt_b, last_a, last_b;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] ic;
        logic [3:0] m;
        logic       locked;
        logic       err;
        logic [7:0] cnt;
        logic [7:0] last;
    } mdl_t;

    typedef struct packed {
        mdl_t a;
        mdl_t b;
    } exp_t;

    mdl_t ma = '0;
    mdl_t mb = '0;
    exp_t q[$];

    always #5 clk = ~clk;

    tick_period_checker #(.counter_width(8), .lock_count(3), .err_width(8)) u_dut_a (
        .sys_clk     (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .locked      (locked_a),
        .period_err  (err_a),
        .err_count   (cnt_a),
        .last_period (last_a)
    );

    tick_period_checker #(.counter_width(8), .lock_count(1), .err_width(8)) u_dut_b (
        .sys_clk     (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .locked      (locked_b),
        .period_err  (err_b),
        .err_count   (cnt_b),
        .last_period (last_b)
    );

    function automatic mdl_t mstep(input mdl_t s, input logic t, input int lc);
        mdl_t n = s;
        n.err = 1'b0;
        n.ic  = t ? 8'd1 : (s.ic == 8'hff ? s.ic : s.ic + 8'd1);
        if (s.st == 2'd0) begin
            if (t) begin
                n.st = 2'd1;
                n.m  = '0;
            end
        end else if (t && s.ic == 8'd9) begin
            n.last = 8'd9;
            if (s.st == 2'd1) begin
                n.m = s.m + 4'd1;
                if (int'(n.m) >= lc) n.st = 2'd2;
            end
        end else if (t) begin
            n.err  = 1'b1;
            n.last = s.ic;
            n.st   = 2'd1;
            n.m    = '0;
        end else if (s.ic == 8'd9) begin
            n.err = 1'b1;
            n.st  = 2'd0;
            n.m   = '0;
        end
        if (n.err && s.cnt != 8'hff) n.cnt = s.cnt + 8'd1;
        n.locked = n.st == 2'd2;
        return n;
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic t);
        exp_t e;
        @(negedge clk);
        tick_in = t;
        ma = mstep(ma, t, 3);
        mb = mstep(mb, t, 1);
        e.a = ma;
        e.b = mb;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("lock_a", locked_a, e.a.locked);
        chk("err_a", err_a, e.a.err);
        chk("cnt_a", cnt_a, e.a.cnt);
        chk("last_a", last_a, e.a.last);
        chk("lock_b", locked_b, e.b.locked);
        chk("err_b", err_b, e.b.err);
        chk("cnt_b", cnt_b, e.b.cnt);
        chk("last_b", last_b, e.b.last);
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            repeat (gap - 1) step(1'b0);
            step(1'b1);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lock"}, locked_a, 0);
        chk({tag, "_err"}, err_a, 0);
        chk({tag, "_cnt"}, cnt_a, 0);
        chk({tag, "_last"}, last_a, 0);
        chk({tag, "_lock_b"}, locked_b, 0);
        chk({tag, "_cnt_b"}, cnt_b, 0);
    endtask

    initial begin
        #12;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0);
        step(1'b1);
        ticks(1, 9);
        chk("p6_lock_b", locked_b, 1);
        chk("p6_lock_a", locked_a, 0);
        ticks(1, 9);
        chk("p1_prelock", locked_a, 0);
        ticks(1, 9);
        chk("p1_lock", locked_a, 1);
        chk("p1_cnt", cnt_a, 0);
        chk("p1_last", last_a, 9);

        ticks(1, 6);
        chk("p2_err", err_a, 1);
        chk("p2_lock", locked_a, 0);
        chk("p2_cnt", cnt_a, 1);
        chk("p2_last", last_a, 6);
        ticks(3, 9);
        chk("p2_relock", locked_a, 1);

        repeat (9) step(1'b0);
        chk("p3_err", err_a, 1);
        chk("p3_lock", locked_a, 0);
        chk("p3_last", last_a, 9);
        chk("p3_cnt", cnt_a, 2);
        repeat (3) step(1'b0);
        step(1'b1);
        chk("p3_late_err", err_a, 0);
        ticks(3, 9);
        chk("p3_relock", locked_a, 1);
        chk("p3_cnt2", cnt_a, 2);

        repeat (300) step(1'b1);
        chk("p4_err", err_a, 1);
        chk("p4_cnt", cnt_a, 255);
        chk("p4_lock", locked_a, 0);
        chk("p4_cnt_b", cnt_b, 255);

        repeat (12) step(1'b0);
        step(1'b1);
        ticks(2, 9);
        repeat (3) step(1'b0);
        rst_n = 1'b0;
        #2;
        chk_zero("p5_async");
        ma = '0;
        mb = '0;
        rst_n = 1'b1;
        step(1'b1);
        chk("p5_first_err", err_a, 0);
        ticks(1, 9);
        chk("p5_nolock", locked_a, 0);
        chk("p5_lock_b", locked_b, 1);
        ticks(2, 9);
        chk("p5_lock", locked_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
